// File: rtl/pipe_ctrl_gen_if.sv
// Stall/flush controller bus: stall requests in, stall vector and redirect handshake out.
// The pipeline side drives requests through master; the controller implements slave.
interface pipe_ctrl_gen_if #(
    parameter int NSTAGE = 6,
    parameter int NREQ   = 5,
    parameter int PC_W   = 32
);
    logic [NREQ-1:0]   stallreq;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              new_pc_ready;
    logic [NSTAGE-1:0] stall;
    logic [NREQ-1:0]   stall_src;
    logic              flush;
    logic [PC_W-1:0]   new_pc;
    logic              new_pc_valid;
    logic              busy;
    logic              stall_timeout;
    logic [31:0]       stall_cycles;

    modport master (
        output stallreq, redirect_valid, redirect_pc, new_pc_ready,
        input  stall, stall_src, flush, new_pc, new_pc_valid,
        input  busy, stall_timeout, stall_cycles
    );

    modport slave (
        input  stallreq, redirect_valid, redirect_pc, new_pc_ready,
        output stall, stall_src, flush, new_pc, new_pc_valid,
        output busy, stall_timeout, stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl_gen.sv
// Pipeline stall arbiter and redirect flush sequencer with
// stall watchdog and stall-cycle counter.
module pipe_ctrl_gen #(
    parameter int NSTAGE = 6,
    parameter int NREQ   = 5,
    parameter logic [NREQ*NSTAGE-1:0] STALL_MAP =
        {6'b111_101, 6'b001_111, 6'b001_111, 6'b000_101, 6'b000_001},
    parameter int PC_W         = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int WDOG_LIMIT   = 1023
) (
    input  logic clk,
    input  logic rst,
    pipe_ctrl_gen_if.slave bus
);
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int WW = $clog2(WDOG_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, FLUSH, WAIT_PC} state_t;

    state_t          state;
    logic            flush_q;
    logic [PC_W-1:0] new_pc_q;
    logic            npv_q;
    logic [CW-1:0]   fcnt;
    logic [WW-1:0]   wcnt;
    logic            timeout_q;
    logic [31:0]     cyc_q;

    logic [NSTAGE-1:0] stall;
    logic [NREQ-1:0]   src;
    logic              stall_any;
    logic              hs;

    // Source 0 is the leftmost (most significant) slice of STALL_MAP.
    always_comb begin
        stall = '0;
        src   = '0;
        if (rst && !flush_q && state == IDLE) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (bus.stallreq[i]) begin
                    stall  = STALL_MAP[(NREQ-1-i)*NSTAGE +: NSTAGE];
                    src    = '0;
                    src[i] = 1'b1;
                end
            end
        end
    end

    assign stall_any = |stall;
    assign hs        = npv_q & bus.new_pc_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            flush_q   <= 1'b0;
            new_pc_q  <= '0;
            npv_q     <= 1'b0;
            fcnt      <= '0;
            wcnt      <= '0;
            timeout_q <= 1'b0;
            cyc_q     <= '0;
        end else begin
            if (stall_any) begin
                cyc_q <= cyc_q + 32'd1;
                if (wcnt != WW'(WDOG_LIMIT))
                    wcnt <= wcnt + 1'b1;
                if (wcnt == WW'(WDOG_LIMIT - 1))
                    timeout_q <= 1'b1;
            end else begin
                wcnt <= '0;
            end

            unique case (state)
                IDLE: begin
                    if (bus.redirect_valid) begin
                        new_pc_q  <= bus.redirect_pc;
                        flush_q   <= 1'b1;
                        npv_q     <= 1'b1;
                        fcnt      <= CW'(FLUSH_CYCLES - 1);
                        timeout_q <= 1'b0;
                        state     <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (hs)
                        npv_q <= 1'b0;
                    if (fcnt == '0) begin
                        flush_q <= 1'b0;
                        state   <= (hs || !npv_q) ? IDLE : WAIT_PC;
                    end else begin
                        fcnt <= fcnt - 1'b1;
                    end
                end
                WAIT_PC: begin
                    if (hs) begin
                        npv_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stall         = stall;
    assign bus.stall_src     = src;
    assign bus.flush         = flush_q;
    assign bus.new_pc        = new_pc_q;
    assign bus.new_pc_valid  = npv_q;
    assign bus.busy          = (state != IDLE);
    assign bus.stall_timeout = timeout_q;
    assign bus.stall_cycles  = cyc_q;
endmodule
